// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmit and keyboard receive paths.
package ps2_pkg;

  // Transmit controller states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_ACK     = 3'd3,
    ST_DONE    = 3'd4
  } ps2_state_e;

  // Line levels of the fixed frame bits.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic ACK_BIT   = 1'b0;

  // Frame geometry: data bits, and device clock edges in a full host frame.
  localparam int DATA_BITS = 8;
  localparam int DEV_EDGES = 11;
  // Device edge on which the host drives its last bit (stop).
  localparam int STOP_EDGE = DATA_BITS + 2;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_timer.sv
// Loadable down-counter with zero flag; stops at zero until reloaded.
module ps2_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_sclr_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign o_zero = (cnt_q == {WIDTH{1'b0}});

  // Next count: load has priority over decrement; hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && !o_zero) begin
      cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_send.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts
// out one byte on device clock edges and reports the device acknowledge.
module ps2_send
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  input  logic       i_en,
  input  logic       i_dat,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  output logic       o_clk_oe,
  output logic       o_dat_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e state_q, state_d;
  // Remaining line levels, LSB first: data, parity, then stop fill.
  logic [DATA_BITS+1:0] sh_q, sh_d;
  logic [3:0] idx_q, idx_d;
  logic clk_oe_q, clk_oe_d;
  logic dat_oe_q, dat_oe_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic inh_load, inh_dec, inh_zero;
  logic to_load, to_dec, to_zero;

  ps2_timer #(.WIDTH(IW)) u_inh_timer (
    .clk        (clk),
    .i_sclr_n   (i_sclr_n),
    .i_load     (inh_load),
    .i_load_val (INH_LOAD),
    .i_dec      (inh_dec),
    .o_zero     (inh_zero)
  );

  ps2_timer #(.WIDTH(TW)) u_to_timer (
    .clk        (clk),
    .i_sclr_n   (i_sclr_n),
    .i_load     (to_load),
    .i_load_val (TO_LOAD),
    .i_dec      (to_dec),
    .o_zero     (to_zero)
  );

  // Next-state, timer control and next output values.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    inh_load = 1'b0;
    inh_dec  = 1'b0;
    to_load  = 1'b0;
    to_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (i_byte_en) begin
          sh_d     = {STOP_BIT, odd_parity(i_byte), i_byte};
          idx_d    = 4'd0;
          inh_load = 1'b1;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        if (inh_zero) begin
          // Release clock and pull data low in the same update.
          clk_oe_d = 1'b0;
          dat_oe_d = ~START_BIT;
          to_load  = 1'b1;
          state_d  = ST_REQ;
        end else begin
          inh_dec = 1'b1;
        end
      end
      ST_REQ: begin
        if (i_en) begin
          to_load  = 1'b1;
          dat_oe_d = ~sh_q[0];
          sh_d     = {STOP_BIT, sh_q[DATA_BITS+1:1]};
          idx_d    = idx_q + 4'd1;
          if (idx_d == 4'(STOP_EDGE)) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_REQ;
          end
        end else if (to_zero) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_dec = 1'b1;
        end
      end
      ST_ACK: begin
        if (i_en) begin
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          err_d    = (i_dat != ACK_BIT);
          state_d  = ST_DONE;
        end else if (to_zero) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          to_dec = 1'b1;
        end
      end
      ST_DONE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs with synchronous clear.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      state_q  <= ST_IDLE;
      sh_q     <= {(DATA_BITS+2){1'b0}};
      idx_q    <= 4'd0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_clk_oe = clk_oe_q;
  assign o_dat_oe = dat_oe_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_ps2_send.sv
// Randomised scoreboard bench for ps2_send with a behavioural device model.
module tb_ps2_send;

  localparam int INH = 8;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic i_sclr_n, i_en, i_dat, i_byte_en;
  logic [7:0] i_byte;
  logic o_clk_oe, o_dat_oe, o_busy, o_done, o_err;

  ps2_send #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .i_sclr_n  (i_sclr_n),
    .i_en      (i_en),
    .i_dat     (i_dat),
    .i_byte_en (i_byte_en),
    .i_byte    (i_byte),
    .o_clk_oe  (o_clk_oe),
    .o_dat_oe  (o_dat_oe),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    int          nbits;
    logic [11:0] bits;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int overlap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: line levels seen after each device edge, from frame rules.
  function automatic exp_t build_exp(input logic [7:0] b, input logic ack,
                                     input int n_edges, input bit timeout);
    exp_t e;
    int ones = 0;
    e.bits = '0;
    e.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e.bits[i+1] = (b >> i) & 1;
      ones += (b >> i) & 1;
    end
    e.bits[9]  = (ones % 2 == 0);
    e.bits[10] = 1'b1;
    e.bits[11] = 1'b1;
    for (int i = 0; i < 12; i++) if (i > n_edges) e.bits[i] = 1'b0;
    e.nbits = n_edges;
    e.err   = timeout ? 1'b1 : (ack != 1'b0);
    e.gap   = timeout ? TMO : -1;
    return e;
  endfunction

  // Monitor: records the frame on the wire and checks it when o_done fires.
  logic prev_clk_oe = 1'b0, en_prev = 1'b0;
  int inh_len = 0, nbits = 0, gap = 0;
  logic [11:0] bits = '0;
  bit active = 1'b0;
  always @(negedge clk) begin
    if (o_clk_oe && o_dat_oe) overlap++;
    if (o_clk_oe && !prev_clk_oe) begin
      inh_len = 1; nbits = 0; bits = '0; active = 1'b0;
    end else if (o_clk_oe) begin
      inh_len++;
    end
    if (!o_clk_oe && prev_clk_oe) begin
      bits[0] = ~o_dat_oe;
      active = 1'b1;
    end
    if (en_prev && active && nbits < 11) begin
      nbits++;
      bits[nbits] = ~o_dat_oe;
      gap = 0;
    end else begin
      gap++;
    end
    if (o_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("err", o_err, e.err);
        check("edge_count", nbits, e.nbits);
        check("frame_bits", bits, e.bits);
        check("inhibit_len", inh_len, INH);
        check("oe_at_done", {o_clk_oe, o_dat_oe}, 2'b00);
        if (e.gap >= 0) check("timeout_gap", gap, e.gap);
      end
      active = 1'b0;
    end
    prev_clk_oe = o_clk_oe;
    en_prev = i_en;
  end

  // One host transfer with device emulation. coll_edge: edge arriving exactly
  // at timeout expiry; inj_edge: extra request while busy; rst_edge: reset.
  task automatic run(input logic [7:0] b, input logic ack, input int n_edges,
                     input int coll_edge, input int inj_edge, input int rst_edge);
    int k;
    if (rst_edge == 0) sb.push_back(build_exp(b, ack, n_edges, n_edges < 11));
    i_byte_en = 1'b1; i_byte = b;
    @(posedge clk) #1;
    i_byte_en = 1'b0; i_byte = $urandom;
    check("busy_rise", {o_busy, o_clk_oe}, 2'b11);
    for (int i = 0; i < 40 && o_clk_oe; i++) @(posedge clk) #1;
    check("clk_release", o_clk_oe, 1'b0);
    repeat ($urandom_range(0, 5)) @(posedge clk) #1;
    for (int e = 1; e <= n_edges; e++) begin
      if (e > 1) begin
        k = (e == coll_edge) ? TMO : $urandom_range(2, 8);
        repeat (k - 1) @(posedge clk) #1;
      end
      i_en = 1'b1;
      if (e == 11) i_dat = ack;
      if (e == inj_edge) begin i_byte_en = 1'b1; i_byte = 8'h12; end
      if (e == rst_edge) i_sclr_n = 1'b0;
      @(posedge clk) #1;
      i_en = 1'b0; i_dat = 1'b1; i_byte_en = 1'b0; i_sclr_n = 1'b1;
      if (e == rst_edge) begin
        check("reset_mid", {o_clk_oe, o_dat_oe, o_busy, o_done, o_err}, 5'b0);
        return;
      end
    end
    for (int i = 0; i < 120 && o_busy; i++) @(posedge clk) #1;
    check("busy_fall", o_busy, 1'b0);
    repeat (3) @(posedge clk) #1;
  endtask

  initial begin
    int busy_cnt;
    int n;
    i_sclr_n = 1'b0; i_en = 1'b0; i_dat = 1'b1; i_byte_en = 1'b0; i_byte = 8'h00;
    repeat (3) @(posedge clk) #1;
    check("reset_state", {o_clk_oe, o_dat_oe, o_busy, o_done, o_err}, 5'b0);
    i_sclr_n = 1'b1;
    @(posedge clk) #1;

    run(8'hED, 1'b0, 11, 0, 0, 0);
    run(8'h00, 1'b1, 11, 0, 0, 0);
    run(8'hFF, 1'b0, 4, 0, 0, 0);
    run(8'hF4, 1'b0, 11, 0, 2, 0);
    busy_cnt = 0;
    repeat (20) begin
      @(posedge clk) #1;
      if (o_busy) busy_cnt++;
    end
    check("no_second_xfer", busy_cnt, 0);
    run(8'hF4, 1'b0, 5, 0, 0, 5);
    repeat (2) @(posedge clk) #1;
    run(8'hF4, 1'b0, 11, 0, 0, 0);
    run(8'($urandom), 1'b0, 11, 3, 0, 0);
    for (int t = 0; t < 8; t++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 11;
      run(8'($urandom), 1'($urandom_range(0, 1)), n, 0, 0, 0);
    end

    check("scoreboard_empty", sb.size(), 0);
    check("oe_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
